load_align_unit: RTL and testbench
==================================

# load_align_unit

Sequential load-data unit between the LSU and the data-memory port. It takes one load request with a byte address, size and signedness, and issues one aligned memory beat, or two when the access crosses a bus word. It merges the beats, extracts and sign- or zero-extends the loaded value, and returns it through a valid/ready response. It is the parametrised successor of the combinational load extender: it adds configurable data width, misaligned-access support or trapping, and a request/response handshake.

## Interface
- XLEN, 32, data/address width; legal values 32 or 64; bus word = XLEN/8 bytes
- ALLOW_MISALIGNED, 1, 1 = split crossing accesses into two beats; 0 = report a fault instead
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  load request valid
- o_req_ready  out  1  unit can accept a request (IDLE only)
- i_addr  in  XLEN  byte address
- i_memSize  in  2  00 word (4 B), 01 half, 10/11 byte
- i_signed  in  1  1 sign-extend, 0 zero-extend
- o_mem_req  out  1  memory beat request, held until i_mem_rvalid
- o_mem_addr  out  XLEN  bus-word-aligned address (low log2(XLEN/8) bits = 0)
- i_mem_rvalid  in  1  read data valid; completes the current beat
- i_mem_rdata  in  XLEN  read data, little-endian lanes
- o_rsp_valid  out  1  response valid, held until i_rsp_ready
- i_rsp_ready  in  1  consumer accepts response
- o_rsp_data  out  XLEN  extended load value
- o_rsp_fault  out  1  misaligned access rejected (ALLOW_MISALIGNED=0 only)

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch addr, size, signed → BEAT0. If the access is misaligned and ALLOW_MISALIGNED=0 → RESP with fault=1, data=0, and no memory beat.
- Misaligned: a half with addr[0]≠0, or a word with addr[1:0]≠0. Crossing: offset + size_bytes > XLEN/8, where offset = addr mod (XLEN/8).
- BEAT0: o_mem_req=1, o_mem_addr = addr with low bits cleared. On i_mem_rvalid, store rdata as lo → BEAT1 if crossing, else RESP.
- BEAT1: o_mem_addr = aligned addr + XLEN/8, wrapping modulo 2^XLEN. On i_mem_rvalid, store rdata as hi → RESP.
- Merge: {hi, lo} >> (offset·8). Take the low 8/16/32 bits and extend to XLEN per i_signed. A 32-bit word on XLEN=64 is also extended.
- RESP: o_rsp_valid=1 with data and fault stable. On i_rsp_ready → IDLE.
- i_mem_rvalid outside BEAT0/BEAT1 is ignored.

## Timing
- Reset values: state IDLE, o_req_ready=1, o_mem_req=0, o_mem_addr=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_fault=0.
- Reset mid-operation abandons the access immediately. No response is issued.
- Accept cycle N. o_mem_req asserts in N+1.
- With rvalid in the same cycle as the request, o_rsp_valid asserts in N+2 for a single beat and N+3 for a split access. Each memory wait cycle adds 1.
- Fault path: o_rsp_valid in N+1.
- Response and accept never overlap. The next request is accepted at the earliest in the cycle after the i_rsp_ready handshake, because ready is high only in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from i_mem_rdata to o_rsp_data.

## Structure
- Shared package load_align_pkg: memSize encodings (MEM_WORD, MEM_HALF, MEM_BYTE), state enum, and a function size_bytes(memSize).
- One combinational sub-module, load_extend (XLEN): inputs {hi, lo}, offset, memSize, signed; output the extended value. It is reused by the store-side aligner later.

## Test plan
- XLEN=32, lb signed at 0x1003, rdata 0x80_11_22_33 → one beat at 0x1000; rsp_data 0xFFFFFF80, latency 2.
- lhu at 0x2003, beats 0x2000 = 0xAB000000 and 0x2004 = 0x000000CD → two beats; rsp_data 0x0000CDAB.
- lw at 0xFFFFFFFE, ALLOW_MISALIGNED=1 → second beat address 0x00000000 (wrap); data merged correctly.
- ALLOW_MISALIGNED=0, lh at 0x11 → no o_mem_req; o_rsp_fault=1, data 0, o_rsp_valid in N+1.
- XLEN=64, lw signed at 0x4, rdata 0x8000_0001_xxxx_xxxx → rsp 0xFFFFFFFF80000001. Hold i_rsp_ready=0 for 3 cycles → data stable, o_req_ready=0.
- Assert i_rst during BEAT1 with 2 memory wait cycles → all outputs return to reset values the same cycle; a late i_mem_rvalid is ignored.

Source files
------------

// File: rtl/load_align_pkg.sv
// ---------------------------------------------------------------------------
// load_align_pkg
//   Shared definitions for the load alignment path:
//     - memSize encodings (MEM_WORD / MEM_HALF / MEM_BYTE)
//     - state_e : the load_align_unit FSM states
//     - size_bytes() : access size in bytes for a memSize code
//   No ports (package).
// ---------------------------------------------------------------------------
package load_align_pkg;

   // memSize encodings; both 2'b10 and 2'b11 mean a byte access.
   localparam logic [1:0] MEM_WORD = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_BYTE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Number of bytes touched by an access of the given size code.
   function automatic logic [3:0] size_bytes(input logic [1:0] mem_size);
      logic [3:0] n;
      case (mem_size)
         MEM_WORD: n = 4'd4;
         MEM_HALF: n = 4'd2;
         default:  n = 4'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational extractor/extender. Treats {hi, lo} as one little-endian
//   byte stream, picks the access starting at byte 'offset', keeps 8/16/32
//   bits depending on memSize and sign- or zero-extends the result to XLEN.
//
//   Ports
//     merged_i   [2*XLEN-1:0]  {hi, lo} bus words (hi may be 0 for 1 beat)
//     offset_i   [OFFW-1:0]    byte offset of the access inside lo
//     mem_size_i [1:0]         MEM_WORD / MEM_HALF / MEM_BYTE
//     signed_i                 1 = sign-extend, 0 = zero-extend
//     data_o     [XLEN-1:0]    extended load value
// ---------------------------------------------------------------------------
module load_extend
   import load_align_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0]         merged_i,
   input  logic [$clog2(XLEN/8)-1:0] offset_i,
   input  logic [1:0]                mem_size_i,
   input  logic                      signed_i,
   output logic [XLEN-1:0]           data_o
);

   logic [31:0] picked;
   logic        sign_bit;

   always_comb begin
      // Gather the four bytes following the offset. offset+3 never runs past
      // the end of {hi, lo} since offset < XLEN/8.
      picked = '0;
      for (int k = 0; k < 4; k++) begin
         picked[k*8 +: 8] = merged_i[(int'(offset_i) + k)*8 +: 8];
      end

      sign_bit = 1'b0;
      data_o   = '0;
      case (mem_size_i)
         MEM_WORD: begin
            sign_bit     = signed_i & picked[31];
            data_o       = {XLEN{sign_bit}};
            data_o[31:0] = picked;
         end
         MEM_HALF: begin
            sign_bit     = signed_i & picked[15];
            data_o       = {XLEN{sign_bit}};
            data_o[15:0] = picked[15:0];
         end
         default: begin
            sign_bit    = signed_i & picked[7];
            data_o      = {XLEN{sign_bit}};
            data_o[7:0] = picked[7:0];
         end
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// ---------------------------------------------------------------------------
// load_align_unit
//   Sequential load-data unit between the LSU and the data-memory port.
//   Accepts one load (byte address, size, signedness), issues one aligned
//   memory beat or two when the access crosses a bus word, merges the beats,
//   extracts and extends the value and returns it on a response channel.
//   With ALLOW_MISALIGNED=0 a misaligned access is answered with a fault and
//   never reaches memory.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. o_req_ready is high only in IDLE; o_mem_req and o_mem_addr are
//   held until i_mem_rvalid completes the beat; o_rsp_valid, o_rsp_data and
//   o_rsp_fault are held stable until i_rsp_ready. i_mem_rvalid outside a
//   beat state is ignored.
//
//   Ports
//     i_clk, i_rst            clock, async active-high reset
//     i_req_valid/o_req_ready load request handshake
//     i_addr, i_memSize, i_signed  request payload
//     o_mem_req, o_mem_addr   aligned memory beat request
//     i_mem_rvalid, i_mem_rdata    memory read return
//     o_rsp_valid/i_rsp_ready response handshake
//     o_rsp_data, o_rsp_fault response payload
// ---------------------------------------------------------------------------
module load_align_unit
   import load_align_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [XLEN-1:0] i_addr,
   input  logic [1:0]      i_memSize,
   input  logic            i_signed,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_rvalid,
   input  logic [XLEN-1:0] i_mem_rdata,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [XLEN-1:0] o_rsp_data,
   output logic            o_rsp_fault
);

   localparam int BUS_BYTES = XLEN / 8;
   localparam int OFFW      = $clog2(BUS_BYTES);

   state_e            state_q;
   logic [XLEN-1:0]   addr_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   rsp_data_q;
   logic              rsp_fault_q;

   logic              req_misaligned_d;
   logic              crossing_d;
   logic [OFFW-1:0]   offset_d;
   logic [XLEN-1:0]   aligned_addr_d;
   logic [XLEN-1:0]   next_addr_d;
   logic [2*XLEN-1:0] merged_d;
   logic [XLEN-1:0]   ext_data_d;

   // Request classification is done on the incoming address so the fault
   // decision is taken in the accept cycle.
   always_comb begin
      req_misaligned_d = 1'b0;
      if (i_memSize == MEM_WORD) begin
         req_misaligned_d = (i_addr[1:0] != 2'b00);
      end else if (i_memSize == MEM_HALF) begin
         req_misaligned_d = i_addr[0];
      end
   end

   always_comb begin
      offset_d       = addr_q[OFFW-1:0];
      crossing_d     = (int'(offset_d) + int'(size_bytes(size_q))) > BUS_BYTES;
      aligned_addr_d = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
      // Plain XLEN-bit add wraps modulo 2^XLEN at the top of the space.
      next_addr_d    = aligned_addr_d + XLEN'(BUS_BYTES);
   end

   // In BEAT1 the returning word is hi and the stored word is lo; in BEAT0
   // a non-crossing access needs only lo, so hi is zero-filled.
   always_comb begin
      if (state_q == ST_BEAT1) begin
         merged_d = {i_mem_rdata, lo_q};
      end else begin
         merged_d = {{XLEN{1'b0}}, i_mem_rdata};
      end
   end

   load_extend #(
      .XLEN(XLEN)
   ) u_extend (
      .merged_i  (merged_d),
      .offset_i  (offset_d),
      .mem_size_i(size_q),
      .signed_i  (signed_q),
      .data_o    (ext_data_d)
   );

   // The extended value is captured into rsp_data_q, so o_rsp_data never
   // has a combinational path from i_mem_rdata.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         size_q      <= MEM_WORD;
         signed_q    <= 1'b0;
         lo_q        <= '0;
         rsp_data_q  <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_req_valid) begin
                  addr_q   <= i_addr;
                  size_q   <= i_memSize;
                  signed_q <= i_signed;
                  if (!ALLOW_MISALIGNED && req_misaligned_d) begin
                     rsp_fault_q <= 1'b1;
                     rsp_data_q  <= '0;
                     state_q     <= ST_RESP;
                  end else begin
                     rsp_fault_q <= 1'b0;
                     state_q     <= ST_BEAT0;
                  end
               end
            end
            ST_BEAT0: begin
               if (i_mem_rvalid) begin
                  lo_q <= i_mem_rdata;
                  if (crossing_d) begin
                     state_q <= ST_BEAT1;
                  end else begin
                     rsp_data_q <= ext_data_d;
                     state_q    <= ST_RESP;
                  end
               end
            end
            ST_BEAT1: begin
               if (i_mem_rvalid) begin
                  rsp_data_q <= ext_data_d;
                  state_q    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Handshake and address outputs are pure state decodes.
   always_comb begin
      o_req_ready = (state_q == ST_IDLE);
      o_mem_req   = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
      o_rsp_valid = (state_q == ST_RESP);
      o_rsp_data  = rsp_data_q;
      o_rsp_fault = rsp_fault_q;
      case (state_q)
         ST_BEAT0: o_mem_addr = aligned_addr_d;
         ST_BEAT1: o_mem_addr = next_addr_d;
         default:  o_mem_addr = '0;
      endcase
   end

endmodule

// File: tb/tb_load_align_unit.sv
// ---------------------------------------------------------------------------
// tb_load_align_unit
//   Directed bench for load_align_unit with three instances:
//     a_ : XLEN=32, ALLOW_MISALIGNED=1
//     f_ : XLEN=32, ALLOW_MISALIGNED=0
//     w_ : XLEN=64, ALLOW_MISALIGNED=1
// ---------------------------------------------------------------------------
module tb_load_align_unit;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // instance a
   logic        a_req_valid, a_req_ready, a_sgn, a_mem_req, a_mem_rvalid;
   logic        a_rsp_valid, a_rsp_ready, a_rsp_fault;
   logic [1:0]  a_size;
   logic [31:0] a_addr, a_mem_addr, a_mem_rdata, a_rsp_data;
   // instance f
   logic        f_req_valid, f_req_ready, f_sgn, f_mem_req, f_mem_rvalid;
   logic        f_rsp_valid, f_rsp_ready, f_rsp_fault;
   logic [1:0]  f_size;
   logic [31:0] f_addr, f_mem_addr, f_mem_rdata, f_rsp_data;
   // instance w
   logic        w_req_valid, w_req_ready, w_sgn, w_mem_req, w_mem_rvalid;
   logic        w_rsp_valid, w_rsp_ready, w_rsp_fault;
   logic [1:0]  w_size;
   logic [63:0] w_addr, w_mem_addr, w_mem_rdata, w_rsp_data;

   int total = 0;
   int bad   = 0;

   load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
      .i_addr(a_addr), .i_memSize(a_size), .i_signed(a_sgn),
      .o_mem_req(a_mem_req), .o_mem_addr(a_mem_addr),
      .i_mem_rvalid(a_mem_rvalid), .i_mem_rdata(a_mem_rdata),
      .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
      .o_rsp_data(a_rsp_data), .o_rsp_fault(a_rsp_fault)
   );

   load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_f (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(f_req_valid), .o_req_ready(f_req_ready),
      .i_addr(f_addr), .i_memSize(f_size), .i_signed(f_sgn),
      .o_mem_req(f_mem_req), .o_mem_addr(f_mem_addr),
      .i_mem_rvalid(f_mem_rvalid), .i_mem_rdata(f_mem_rdata),
      .o_rsp_valid(f_rsp_valid), .i_rsp_ready(f_rsp_ready),
      .o_rsp_data(f_rsp_data), .o_rsp_fault(f_rsp_fault)
   );

   load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) dut_w (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(w_req_valid), .o_req_ready(w_req_ready),
      .i_addr(w_addr), .i_memSize(w_size), .i_signed(w_sgn),
      .o_mem_req(w_mem_req), .o_mem_addr(w_mem_addr),
      .i_mem_rvalid(w_mem_rvalid), .i_mem_rdata(w_mem_rdata),
      .o_rsp_valid(w_rsp_valid), .i_rsp_ready(w_rsp_ready),
      .o_rsp_data(w_rsp_data), .o_rsp_fault(w_rsp_fault)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
      total++; if (a_mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", a_mem_req); end
      total++; if (a_mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", a_mem_addr); end
      total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
      total++; if (a_rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", a_rsp_data); end
      total++; if (a_rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault got=%b exp=0", a_rsp_fault); end
      total++; if (w_req_ready !== 1'b1 || w_mem_req !== 1'b0 || w_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_w64 got ready=%b mem_req=%b rsp_valid=%b exp 1/0/0", w_req_ready, w_mem_req, w_rsp_valid);
      end
      rst = 1'b0;
      step();
   endtask

   // lb signed at 0x1003, rvalid already high with the request.
   task automatic test_single_beat();
      total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL lb_ready_before got=%b exp=1", a_req_ready); end
      a_req_valid = 1'b1; a_addr = 32'h0000_1003; a_size = 2'b10; a_sgn = 1'b1;
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'h8011_2233;
      step();                                   // N+1
      a_req_valid = 1'b0;
      total++; if (a_mem_req !== 1'b1) begin bad++; $display("FAIL lb_mem_req got=%b exp=1", a_mem_req); end
      total++; if (a_mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL lb_mem_addr got=%h exp=00001000", a_mem_addr); end
      total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL lb_rsp_early got=%b exp=0", a_rsp_valid); end
      step();                                   // N+2
      a_mem_rvalid = 1'b0;
      total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL lb_rsp_valid got=%b exp=1", a_rsp_valid); end
      total++; if (a_rsp_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rsp_data got=%h exp=ffffff80", a_rsp_data); end
      total++; if (a_mem_req !== 1'b0 || a_req_ready !== 1'b0) begin
         bad++; $display("FAIL lb_resp_state got mem_req=%b ready=%b exp 0/0", a_mem_req, a_req_ready);
      end
      a_rsp_ready = 1'b1;
      step();
      a_rsp_ready = 1'b0;
      total++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL lb_back_idle got ready=%b rsp_valid=%b exp 1/0", a_req_ready, a_rsp_valid);
      end
   endtask

   // lhu at 0x2003 crossing into 0x2004, with one wait cycle in BEAT0.
   task automatic test_split();
      a_req_valid = 1'b1; a_addr = 32'h0000_2003; a_size = 2'b01; a_sgn = 1'b0;
      step();                                   // N+1 BEAT0, no data yet
      a_req_valid = 1'b0;
      total++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_2000) begin
         bad++; $display("FAIL lhu_beat0 got req=%b addr=%h exp 1/00002000", a_mem_req, a_mem_addr);
      end
      step();                                   // N+2 still BEAT0 (wait)
      total++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_2000) begin
         bad++; $display("FAIL lhu_beat0_hold got req=%b addr=%h exp 1/00002000", a_mem_req, a_mem_addr);
      end
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'hAB00_0000;
      step();                                   // N+3 BEAT1
      a_mem_rdata = 32'h0000_00CD;
      total++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_2004) begin
         bad++; $display("FAIL lhu_beat1 got req=%b addr=%h exp 1/00002004", a_mem_req, a_mem_addr);
      end
      total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL lhu_rsp_early got=%b exp=0", a_rsp_valid); end
      step();                                   // N+4 RESP
      a_mem_rvalid = 1'b0;
      total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0000_CDAB) begin
         bad++; $display("FAIL lhu_rsp got valid=%b data=%h exp 1/0000cdab", a_rsp_valid, a_rsp_data);
      end
      a_rsp_ready = 1'b1;
      step();
      a_rsp_ready = 1'b0;
   endtask

   // lw at 0xFFFFFFFE: second beat wraps to address 0.
   task automatic test_wrap();
      a_req_valid = 1'b1; a_addr = 32'hFFFF_FFFE; a_size = 2'b00; a_sgn = 1'b1;
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'hBBAA_1122;
      step();                                   // BEAT0
      a_req_valid = 1'b0;
      total++; if (a_mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_beat0_addr got=%h exp=fffffffc", a_mem_addr); end
      step();                                   // BEAT1
      a_mem_rdata = 32'h5566_7788;
      total++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_0000) begin
         bad++; $display("FAIL wrap_beat1_addr got req=%b addr=%h exp 1/00000000", a_mem_req, a_mem_addr);
      end
      step();                                   // RESP
      a_mem_rvalid = 1'b0;
      total++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h7788_BBAA) begin
         bad++; $display("FAIL wrap_rsp got valid=%b data=%h exp 1/7788bbaa", a_rsp_valid, a_rsp_data);
      end
      a_rsp_ready = 1'b1;
      step();
      a_rsp_ready = 1'b0;
   endtask

   // Trapping instance: aligned lh works, misaligned lh faults without a beat.
   task automatic test_fault();
      f_req_valid = 1'b1; f_addr = 32'h0000_0012; f_size = 2'b01; f_sgn = 1'b1;
      f_mem_rvalid = 1'b1; f_mem_rdata = 32'h8001_7777;
      step();
      f_req_valid = 1'b0;
      total++; if (f_mem_req !== 1'b1 || f_mem_addr !== 32'h0000_0010) begin
         bad++; $display("FAIL flh_beat got req=%b addr=%h exp 1/00000010", f_mem_req, f_mem_addr);
      end
      step();
      f_mem_rvalid = 1'b0;
      total++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hFFFF_8001 || f_rsp_fault !== 1'b0) begin
         bad++; $display("FAIL flh_rsp got valid=%b data=%h fault=%b exp 1/ffff8001/0", f_rsp_valid, f_rsp_data, f_rsp_fault);
      end
      f_rsp_ready = 1'b1;
      step();
      f_rsp_ready = 1'b0;
      // misaligned half at 0x11
      f_req_valid = 1'b1; f_addr = 32'h0000_0011; f_size = 2'b01; f_sgn = 1'b0;
      step();                                   // N+1
      f_req_valid = 1'b0;
      total++; if (f_mem_req !== 1'b0) begin bad++; $display("FAIL fault_mem_req got=%b exp=0", f_mem_req); end
      total++; if (f_rsp_valid !== 1'b1 || f_rsp_fault !== 1'b1) begin
         bad++; $display("FAIL fault_rsp got valid=%b fault=%b exp 1/1", f_rsp_valid, f_rsp_fault);
      end
      total++; if (f_rsp_data !== 32'h0) begin bad++; $display("FAIL fault_data got=%h exp=0", f_rsp_data); end
      f_rsp_ready = 1'b1;
      step();
      f_rsp_ready = 1'b0;
      total++; if (f_req_ready !== 1'b1 || f_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL fault_back_idle got ready=%b valid=%b exp 1/0", f_req_ready, f_rsp_valid);
      end
   endtask

   // XLEN=64: lw signed in upper half, response held under backpressure;
   // then a crossing lh at 0x7.
   task automatic test_xlen64();
      w_req_valid = 1'b1; w_addr = 64'h4; w_size = 2'b00; w_sgn = 1'b1;
      w_mem_rvalid = 1'b1; w_mem_rdata = 64'h8000_0001_DEAD_BEEF;
      step();
      w_req_valid = 1'b0;
      total++; if (w_mem_addr !== 64'h0) begin bad++; $display("FAIL w64_lw_addr got=%h exp=0", w_mem_addr); end
      step();
      w_mem_rvalid = 1'b0; w_mem_rdata = 64'h0;
      for (int i = 0; i < 3; i++) begin
         total++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 64'hFFFF_FFFF_8000_0001 || w_req_ready !== 1'b0) begin
            bad++; $display("FAIL w64_lw_hold%0d got valid=%b data=%h ready=%b exp 1/ffffffff80000001/0", i, w_rsp_valid, w_rsp_data, w_req_ready);
         end
         step();
      end
      w_rsp_ready = 1'b1;
      step();
      w_rsp_ready = 1'b0;
      w_req_valid = 1'b1; w_addr = 64'h7; w_size = 2'b01; w_sgn = 1'b1;
      w_mem_rvalid = 1'b1; w_mem_rdata = 64'h1200_0000_0000_0000;
      step();                                   // BEAT0
      w_req_valid = 1'b0;
      step();                                   // BEAT1
      w_mem_rdata = 64'h0000_0000_0000_00F3;
      total++; if (w_mem_addr !== 64'h8) begin bad++; $display("FAIL w64_lh_beat1 got=%h exp=8", w_mem_addr); end
      step();
      w_mem_rvalid = 1'b0;
      total++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 64'hFFFF_FFFF_FFFF_F312) begin
         bad++; $display("FAIL w64_lh_rsp got valid=%b data=%h exp 1/fffffffffffff312", w_rsp_valid, w_rsp_data);
      end
      w_rsp_ready = 1'b1;
      step();
      w_rsp_ready = 1'b0;
   endtask

   // Reset in BEAT1 after 2 wait cycles, then a late rvalid.
   task automatic test_reset_mid();
      a_req_valid = 1'b1; a_addr = 32'h0000_2003; a_size = 2'b01; a_sgn = 1'b0;
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'hAB00_0000;
      step();                                   // BEAT0
      a_req_valid = 1'b0;
      step();                                   // BEAT1
      a_mem_rvalid = 1'b0;
      step();
      step();                                   // two wait cycles in BEAT1
      total++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_2004) begin
         bad++; $display("FAIL rmid_in_beat1 got req=%b addr=%h exp 1/00002004", a_mem_req, a_mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      total++; if (a_req_ready !== 1'b1 || a_mem_req !== 1'b0 || a_mem_addr !== 32'h0 ||
                   a_rsp_valid !== 1'b0 || a_rsp_data !== 32'h0 || a_rsp_fault !== 1'b0) begin
         bad++; $display("FAIL rmid_async got ready=%b req=%b addr=%h valid=%b data=%h fault=%b exp 1/0/0/0/0/0",
                         a_req_ready, a_mem_req, a_mem_addr, a_rsp_valid, a_rsp_data, a_rsp_fault);
      end
      step();
      rst = 1'b0;
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'h0000_00CD;
      step();
      step();
      a_mem_rvalid = 1'b0;
      total++; if (a_req_ready !== 1'b1 || a_mem_req !== 1'b0 || a_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL rmid_late_rvalid got ready=%b req=%b valid=%b exp 1/0/0", a_req_ready, a_mem_req, a_rsp_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_req_valid = 0; a_addr = 0; a_size = 0; a_sgn = 0; a_mem_rvalid = 0; a_mem_rdata = 0; a_rsp_ready = 0;
      f_req_valid = 0; f_addr = 0; f_size = 0; f_sgn = 0; f_mem_rvalid = 0; f_mem_rdata = 0; f_rsp_ready = 0;
      w_req_valid = 0; w_addr = 0; w_size = 0; w_sgn = 0; w_mem_rvalid = 0; w_mem_rdata = 0; w_rsp_ready = 0;
      test_reset();
      test_single_beat();
      test_split();
      test_wrap();
      test_fault();
      test_xlen64();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
